// File: rtl/egress_port.sv
// Egress port: buffers packets routed to this output from the crossbar and
// presents them downstream with a valid/ready handshake. Counts discarded
// packets and flags a downstream stall that lasts too long.
module egress_port #(
   parameter int PORT_ID      = 0,
   parameter int DEPTH        = 4,
   parameter int PACKET_WIDTH = 16,
   parameter int STALL_LIMIT  = 15
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      xbar_valid,
   input  logic [PACKET_WIDTH-1:0]   xbar_data,
   input  logic [1:0]                xbar_src,
   output logic                      egress_full,
   output logic                      out_valid,
   output logic [PACKET_WIDTH-1:0]   out_data,
   output logic [1:0]                out_src,
   input  logic                      out_ready,
   output logic [$clog2(DEPTH):0]    occupancy,
   output logic [7:0]                drop_count,
   output logic                      stall_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);
   localparam int EW = PACKET_WIDTH + 2;

   typedef enum logic {
      IDLE,
      PRESENT
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] occ_q, occ_d;
   logic [7:0]    drop_q, drop_d;
   logic [SW-1:0] stall_cnt_q, stall_cnt_d;
   logic          stall_err_q, stall_err_d;
   logic [EW-1:0] mem_q [DEPTH];

   logic full;
   logic target_hit;
   logic accept;
   logic pop;

   // Full is decoded from the registered count only, so it has no path from xbar_* or out_ready.
   assign full       = (occ_q == CW'(DEPTH));
   assign target_hit = xbar_data[4 + PORT_ID];
   assign accept     = xbar_valid & target_hit & ~full;
   assign pop        = (state_q == PRESENT) & out_ready;

   // Buffer pointers, occupancy and saturating drop counter.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      drop_d   = drop_q;
      if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
      case ({accept, pop})
         2'b10:   occ_d = occ_q + CW'(1);
         2'b01:   occ_d = occ_q - CW'(1);
         default: occ_d = occ_q;
      endcase
      if (xbar_valid && !accept && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
   end

   // Output FSM next state plus stall supervision.
   always_comb begin
      state_d     = state_q;
      stall_cnt_d = '0;
      case (state_q)
         IDLE:    if (occ_q != '0) state_d = PRESENT;
         PRESENT: if (pop && (occ_q <= CW'(1))) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if ((state_q == PRESENT) && !out_ready) begin
         stall_cnt_d = (stall_cnt_q == SW'(STALL_LIMIT)) ? stall_cnt_q : stall_cnt_q + SW'(1);
      end
      stall_err_d = stall_err_q | (stall_cnt_d == SW'(STALL_LIMIT));
   end

   // Control state registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
         drop_q      <= '0;
         stall_cnt_q <= '0;
         stall_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
         drop_q      <= drop_d;
         stall_cnt_q <= stall_cnt_d;
         stall_err_q <= stall_err_d;
      end
   end

   // Packet storage; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (accept) mem_q[wr_ptr_q] <= {xbar_src, xbar_data};
   end

   assign egress_full           = full;
   assign out_valid             = (state_q == PRESENT);
   assign {out_src, out_data}   = mem_q[rd_ptr_q];
   assign occupancy             = occ_q;
   assign drop_count            = drop_q;
   assign stall_err             = stall_err_q;

endmodule

// File: tb/tb_egress_port.sv
// Self-checking bench for egress_port: directed scenarios plus a randomized
// run, checked against a queue-based reference model of the port.
module tb_egress_port;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        xv;
   logic [15:0] xd;
   logic [1:0]  xs;
   logic        rdy;

   logic        full2, ov2, se2;
   logic [15:0] od2;
   logic [1:0]  os2;
   logic [2:0]  occ2;
   logic [7:0]  dc2;

   logic        full0, ov0, se0;
   logic [15:0] od0;
   logic [1:0]  os0;
   logic [2:0]  occ0;
   logic [7:0]  dc0;

   int n_vec = 0;
   int n_err = 0;

   // reference model for the PORT_ID=2 instance
   logic [17:0] mq[$];
   bit          mv;
   int          mdrop;
   int          mscnt;
   bit          merr;

   always #5 clk = ~clk;

   egress_port #(.PORT_ID(2), .DEPTH(4), .PACKET_WIDTH(16), .STALL_LIMIT(15)) u2 (
      .clk(clk), .rst_n(rst_n), .xbar_valid(xv), .xbar_data(xd), .xbar_src(xs),
      .egress_full(full2), .out_valid(ov2), .out_data(od2), .out_src(os2),
      .out_ready(rdy), .occupancy(occ2), .drop_count(dc2), .stall_err(se2));

   egress_port #(.PORT_ID(0), .DEPTH(4), .PACKET_WIDTH(16), .STALL_LIMIT(15)) u0 (
      .clk(clk), .rst_n(rst_n), .xbar_valid(xv), .xbar_data(xd), .xbar_src(xs),
      .egress_full(full0), .out_valid(ov0), .out_data(od0), .out_src(os0),
      .out_ready(rdy), .occupancy(occ0), .drop_count(dc0), .stall_err(se0));

   task automatic model_clear();
      mq.delete();
      mv    = 1'b0;
      mdrop = 0;
      mscnt = 0;
      merr  = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_edge();
      int sz;
      bit hs, acc;
      sz  = mq.size();
      hs  = mv && rdy;
      acc = xv && xd[6] && (sz < 4);
      if (xv && !acc && mdrop < 255) mdrop++;
      if (mv && !rdy) mscnt++;
      else            mscnt = 0;
      if (mscnt >= 15) merr = 1'b1;
      if (!mv)     mv = (sz > 0);
      else if (hs) mv = (sz > 1);
      if (hs)  void'(mq.pop_front());
      if (acc) mq.push_back({xs, xd});
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      xv = 1'b0; xd = '0; xs = '0; rdy = 1'b0;
      model_clear();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      xv = 1'b0; xd = '0; xs = '0; rdy = 1'b0;
      model_clear();
      #1;
      n_vec++; if (ov2 !== 1'b0)   begin n_err++; $display("FAIL reset_valid: got %b expected 0", ov2); end
      n_vec++; if (full2 !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b expected 0", full2); end
      n_vec++; if (occ2 !== 3'd0)  begin n_err++; $display("FAIL reset_occ: got %0d expected 0", occ2); end
      n_vec++; if (dc2 !== 8'd0)   begin n_err++; $display("FAIL reset_drop: got %0d expected 0", dc2); end
      n_vec++; if (se2 !== 1'b0)   begin n_err++; $display("FAIL reset_stall: got %b expected 0", se2); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      xv = 1'b1; xd = 16'hA541; xs = 2'd1; rdy = 1'b1;
      step();
      xv = 1'b0;
      n_vec++; if (ov2 !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %b expected 0", ov2); end
      n_vec++; if (occ2 !== 3'd1) begin n_err++; $display("FAIL single_occ1: got %0d expected 1", occ2); end
      step();
      n_vec++; if (ov2 !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b expected 1", ov2); end
      n_vec++; if (od2 !== 16'hA541) begin n_err++; $display("FAIL single_data: got %h expected a541", od2); end
      n_vec++; if (os2 !== 2'd1) begin n_err++; $display("FAIL single_src: got %0d expected 1", os2); end
      step();
      n_vec++; if (occ2 !== 3'd0) begin n_err++; $display("FAIL single_occ0: got %0d expected 0", occ2); end
      n_vec++; if (ov2 !== 1'b0) begin n_err++; $display("FAIL single_done_valid: got %b expected 0", ov2); end
   endtask

   task automatic test_fill();
      logic [17:0] exp_pkt [5];
      do_reset();
      rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         xv = 1'b1;
         xd = 16'($urandom) | 16'h0040;
         xs = 2'($urandom);
         exp_pkt[i] = {xs, xd};
         step();
      end
      xv = 1'b0;
      n_vec++; if (full2 !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b expected 1", full2); end
      n_vec++; if (dc2 !== 8'd1)   begin n_err++; $display("FAIL fill_drop: got %0d expected 1", dc2); end
      n_vec++; if (occ2 !== 3'd4)  begin n_err++; $display("FAIL fill_occ: got %0d expected 4", occ2); end
      rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (ov2 !== 1'b1) begin n_err++; $display("FAIL fill_drain_valid[%0d]: got %b expected 1", i, ov2); end
         n_vec++; if ({os2, od2} !== exp_pkt[i]) begin
            n_err++; $display("FAIL fill_drain_pkt[%0d]: got %h expected %h", i, {os2, od2}, exp_pkt[i]);
         end
         step();
      end
      n_vec++; if (ov2 !== 1'b0)  begin n_err++; $display("FAIL fill_empty_valid: got %b expected 0", ov2); end
      n_vec++; if (occ2 !== 3'd0) begin n_err++; $display("FAIL fill_empty_occ: got %0d expected 0", occ2); end
      rdy = 1'b0;
   endtask

   task automatic test_misroute();
      do_reset();
      xv = 1'b1; xd = 16'h1220; xs = 2'd2; rdy = 1'b1;
      step();
      xv = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_vec++; if (ov0 !== 1'b0) begin n_err++; $display("FAIL misroute_valid[%0d]: got %b expected 0", i, ov0); end
         step();
      end
      n_vec++; if (dc0 !== 8'd1)  begin n_err++; $display("FAIL misroute_drop: got %0d expected 1", dc0); end
      n_vec++; if (occ0 !== 3'd0) begin n_err++; $display("FAIL misroute_occ: got %0d expected 0", occ0); end
      n_vec++; if (dc2 !== 8'(mdrop)) begin n_err++; $display("FAIL misroute_drop_p2: got %0d expected %0d", dc2, mdrop); end
   endtask

   task automatic test_wrap();
      do_reset();
      rdy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         xv = 1'b1; xd = 16'($urandom) | 16'h0040; xs = 2'($urandom);
         step();
      end
      xv = 1'b0;
      step();
      for (int i = 0; i < 8; i++) begin
         xv = 1'b1; xd = 16'($urandom) | 16'h0040; xs = 2'($urandom); rdy = 1'b1;
         n_vec++; if (ov2 !== 1'b1) begin n_err++; $display("FAIL wrap_valid[%0d]: got %b expected 1", i, ov2); end
         n_vec++; if ({os2, od2} !== mq[0]) begin
            n_err++; $display("FAIL wrap_pkt[%0d]: got %h expected %h", i, {os2, od2}, mq[0]);
         end
         step();
         n_vec++; if (occ2 !== 3'd2) begin n_err++; $display("FAIL wrap_occ[%0d]: got %0d expected 2", i, occ2); end
      end
      xv = 1'b0; rdy = 1'b0;
   endtask

   task automatic test_stall();
      logic [15:0] hold;
      do_reset();
      xv = 1'b1; xd = 16'h5C4E; xs = 2'd3;
      step();
      xv = 1'b0; rdy = 1'b0;
      step();
      hold = 16'h5C4E;
      for (int i = 1; i <= 15; i++) begin
         step();
         n_vec++; if (se2 !== (i >= 15)) begin n_err++; $display("FAIL stall_err[%0d]: got %b expected %b", i, se2, (i >= 15)); end
         n_vec++; if (od2 !== hold) begin n_err++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, od2, hold); end
         n_vec++; if (ov2 !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, ov2); end
      end
      rdy = 1'b1;
      step();
      rdy = 1'b0;
      n_vec++; if (ov2 !== 1'b0) begin n_err++; $display("FAIL stall_pop_valid: got %b expected 0", ov2); end
      step();
      n_vec++; if (se2 !== 1'b1) begin n_err++; $display("FAIL stall_sticky: got %b expected 1", se2); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         xv = 1'b1; xd = 16'($urandom) | 16'h0040; xs = 2'($urandom);
         step();
      end
      xv = 1'b1; xd = 16'h0011; xs = 2'd0;
      step();
      xv = 1'b0;
      n_vec++; if (occ2 !== 3'd3) begin n_err++; $display("FAIL mid_pre_occ: got %0d expected 3", occ2); end
      n_vec++; if (dc2 !== 8'd1)  begin n_err++; $display("FAIL mid_pre_drop: got %0d expected 1", dc2); end
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      n_vec++; if (ov2 !== 1'b0)   begin n_err++; $display("FAIL mid_valid: got %b expected 0", ov2); end
      n_vec++; if (occ2 !== 3'd0)  begin n_err++; $display("FAIL mid_occ: got %0d expected 0", occ2); end
      n_vec++; if (dc2 !== 8'd0)   begin n_err++; $display("FAIL mid_drop: got %0d expected 0", dc2); end
      n_vec++; if (full2 !== 1'b0) begin n_err++; $display("FAIL mid_full: got %b expected 0", full2); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_vec++; if (ov2 !== 1'b0) begin n_err++; $display("FAIL mid_after_valid[%0d]: got %b expected 0", i, ov2); end
      end
      rdy = 1'b0;
   endtask

   task automatic test_drop_saturate();
      do_reset();
      xv = 1'b1; xd = 16'h0F0F; xs = 2'd1;
      for (int i = 0; i < 260; i++) step();
      xv = 1'b0;
      n_vec++; if (dc2 !== 8'd255) begin n_err++; $display("FAIL drop_saturate: got %0d expected 255", dc2); end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 500; i++) begin
         xv  = ($urandom_range(0, 3) != 0);
         xd  = 16'($urandom);
         xs  = 2'($urandom);
         rdy = ($urandom_range(0, 2) != 0);
         step();
         n_vec++; if (ov2 !== mv) begin n_err++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, ov2, mv); end
         if (mv) begin
            n_vec++; if ({os2, od2} !== mq[0]) begin
               n_err++; $display("FAIL rand_pkt[%0d]: got %h expected %h", i, {os2, od2}, mq[0]);
            end
         end
         n_vec++; if (occ2 !== 3'(mq.size())) begin n_err++; $display("FAIL rand_occ[%0d]: got %0d expected %0d", i, occ2, mq.size()); end
         n_vec++; if (full2 !== (mq.size() == 4)) begin n_err++; $display("FAIL rand_full[%0d]: got %b expected %b", i, full2, (mq.size() == 4)); end
         n_vec++; if (dc2 !== 8'(mdrop)) begin n_err++; $display("FAIL rand_drop[%0d]: got %0d expected %0d", i, dc2, mdrop); end
         n_vec++; if (se2 !== merr) begin n_err++; $display("FAIL rand_stall[%0d]: got %b expected %b", i, se2, merr); end
      end
      xv = 1'b0; rdy = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_misroute();
      test_wrap();
      test_stall();
      test_reset_mid();
      test_drop_saturate();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/egress_port.md
EGRESS_PORT -- requirements
Module: egress_port

Interface
REQ-001 Parameter PORT_ID, default 0: index (0-3) of this output; its target-mask bit is bit PORT_ID of the header target field.
REQ-002 Parameter DEPTH, default 4: egress buffer entries; power of two, >= 2.
REQ-003 Parameter PACKET_WIDTH, default 16: packet width; header = bits [7:0], source = [3:0], target = [7:4].
REQ-004 Parameter STALL_LIMIT, default 15: consecutive back-pressured cycles before stall_err sets.
REQ-005 clk  in  1  rising-edge clock; the block's only clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 xbar_valid  in  1  registered crossbar mux delivers a packet this cycle.
REQ-008 xbar_data  in  PACKET_WIDTH  packet from the crossbar mux.
REQ-009 xbar_src  in  2  mux select, i.e. the granted source port index.
REQ-010 egress_full  out  1  buffer full; the arbiter grants no request targeting this output while high.
REQ-011 out_valid  out  1  output packet valid.
REQ-012 out_data  out  PACKET_WIDTH  output packet.
REQ-013 out_src  out  2  source port index stored with the packet.
REQ-014 out_ready  in  1  downstream accepts the packet.
REQ-015 occupancy  out  $clog2(DEPTH)+1  buffered packet count, 0..DEPTH.
REQ-016 drop_count  out  8  saturating count of discarded packets.
REQ-017 stall_err  out  1  sticky downstream-stall flag.

Function
REQ-018 Accept: at an edge with xbar_valid=1, target bit PORT_ID=1 and occupancy<DEPTH, write {xbar_src, xbar_data} at wr_ptr.
REQ-019 Drop: xbar_valid=1 with target bit PORT_ID=0 (misroute), or with occupancy==DEPTH: no write, drop_count +1, saturating at 255.
REQ-020 A write is dropped when occupancy==DEPTH even if a pop occurs on the same edge.
REQ-021 egress_full = (occupancy==DEPTH), decoded from the registered count, with no combinational path from xbar_* or out_ready.
REQ-022 wr_ptr and rd_ptr wrap modulo DEPTH.
REQ-023 Simultaneous write and pop: occupancy unchanged, both pointers advance.
REQ-024 Output FSM states: IDLE, PRESENT.
REQ-025 IDLE: out_valid=0; move to PRESENT on the next edge when occupancy>0.
REQ-026 PRESENT: out_valid=1; out_data and out_src = buffer entry at rd_ptr.
REQ-027 Handshake (out_valid & out_ready at an edge): pop the entry; stay PRESENT if occupancy>1 before the pop, else go to IDLE.
REQ-028 Throughput: back-to-back handshakes transfer one packet per cycle.
REQ-029 Stability: while out_valid=1 and out_ready=0, out_data and out_src hold and out_valid stays 1.
REQ-030 Latency: a packet accepted at edge N into an empty buffer has out_valid=1 after edge N+1.
REQ-031 Stall counter: increments each edge in PRESENT with out_ready=0; clears on handshake or in IDLE.
REQ-032 stall_err sets when the stall counter reaches STALL_LIMIT and stays set until reset.
REQ-033 Packets leave in acceptance order; no duplication or reordering.

Reset
REQ-034 rst_n=0 asynchronously clears the pointers, occupancy, drop_count, stall counter and stall_err, forces the FSM to IDLE and drives out_valid=0 and egress_full=0.
REQ-035 Reset mid-transfer discards all buffered packets; no packet is emitted after release until a new accept.
REQ-036 Buffer memory contents are not reset; out_data is don't-care while out_valid=0.

Verification
REQ-037 PORT_ID=2: one xbar_valid with xbar_data=16'hA541, xbar_src=1, out_ready=1 -> out_valid high one edge later, out_data=16'hA541, out_src=1, occupancy returns to 0.
REQ-038 out_ready=0; 5 packets with target bit set -> first 4 stored, egress_full=1, drop_count=1; then out_ready=1 -> 4 packets out in order on 4 consecutive cycles.
REQ-039 PORT_ID=0: packet with target=4'b0010 -> no write, drop_count=1, out_valid stays 0.
REQ-040 occupancy=2 with simultaneous accept and handshake each cycle for 8 cycles -> occupancy stays 2, pointers wrap, order preserved.
REQ-041 out_valid=1 and out_ready=0 for 15 cycles -> stall_err=1 and out_data unchanged; a later handshake leaves stall_err=1.
REQ-042 rst_n pulsed low for one cycle while occupancy=3 -> out_valid=0, occupancy=0 and drop_count=0 immediately, with no output until a new accept.
